// File: rtl/demux1to4_buf.sv
// ============================================================================
// Module      : demux1to4_buf
// Description : Buffered 1-to-4 demultiplexer. One input word per cycle is
//               steered by in_sel into one of four independent lane FIFOs,
//               each with its own valid/ready output handshake, so a stalled
//               destination never blocks the other lanes.
//               Optional feature macro: DEMUX_LEVEL_EN (adds lane_level port
//               carrying each lane's registered occupancy count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to4_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_sel,
    input  logic [WIDTH-1:0]       in_data,
    output logic [3:0]             out_valid,
    input  logic [3:0]             out_ready,
    output logic [4*WIDTH-1:0]     out_data
`ifdef DEMUX_LEVEL_EN
    ,
    output logic [4*($clog2(DEPTH)+1)-1:0] lane_level
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] C_FULL_COUNT = CW'(DEPTH);

    logic [3:0] lane_full;

    // Input is refused purely on registered fullness of the addressed lane;
    // a same-cycle pop on that lane does not open it up.
    assign in_ready = ~lane_full[in_sel];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [WIDTH-1:0] mem_d [DEPTH];
        logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
        logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
        logic [CW-1:0]    count_q,  count_d;
        logic             push;
        logic             pop;

        assign lane_full[k] = (count_q == C_FULL_COUNT);
        assign push         = in_valid & in_ready & (in_sel == 2'(k));
        assign pop          = out_valid[k] & out_ready[k];

        assign out_valid[k]                = (count_q != '0);
        assign out_data[k*WIDTH +: WIDTH]  = mem_q[rd_ptr_q];

        // Next-state for this lane: write at wr_ptr, read at rd_ptr, count tracks net change
        always_comb begin
            mem_d    = mem_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Lane state register; storage is cleared too so out_data reads 0 after reset
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                mem_q    <= mem_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                count_q  <= count_d;
            end
        end

`ifdef DEMUX_LEVEL_EN
        assign lane_level[k*CW +: CW] = count_q;
`endif
    end

endmodule

`default_nettype wire

// File: tb/tb_demux1to4_buf.sv
// ============================================================================
// Module      : tb_demux1to4_buf
// Description : Directed testbench for demux1to4_buf with a per-lane
//               scoreboard of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1to4_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_sel;
    logic [WIDTH-1:0]   in_data;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;

    int tests;
    int fails;

    logic [WIDTH-1:0] sb [4][$];

    demux1to4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs against the scoreboard,
    // then advance the scoreboard by the handshakes the bench expects.
    task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                        input logic [3:0] r);
        logic       exp_rdy;
        logic [3:0] exp_vld;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        #1;
        exp_rdy = (sb[s].size() < DEPTH);
        chk($sformatf("in_ready sel=%0d", s), {31'd0, in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 4; k++) begin
            exp_vld[k] = (sb[k].size() != 0);
            chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]}, {31'd0, exp_vld[k]});
            if (exp_vld[k])
                chk($sformatf("out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], sb[k][0]);
        end
        for (int k = 0; k < 4; k++) begin
            if (exp_vld[k] && r[k]) void'(sb[k].pop_front());
        end
        if (v && exp_rdy) sb[s].push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 2'd0;
        in_data   = '0;
        out_ready = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset out_valid", {28'd0, out_valid}, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1: idle after reset
        chk("idle out_valid", {28'd0, out_valid}, 32'd0);
        chk("idle in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("idle out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], 32'd0);

        // 2: single word to lane 2, visible one cycle later
        step(1'b1, 2'd2, 32'hA5A5_0001, 4'b0000);
        chk("lane2 out_valid vector", {28'd0, out_valid}, 32'h0000_0004);
        step(1'b0, 2'd0, 32'h0, 4'b0100);

        // 3: overfill lane 1, then drain in order; stalled word enters after first pop
        step(1'b1, 2'd1, 32'h1111_0001, 4'b0000);
        step(1'b1, 2'd1, 32'h1111_0002, 4'b0000);
        step(1'b1, 2'd1, 32'h1111_0003, 4'b0000);
        chk("lane1 full in_ready", {31'd0, in_ready}, 32'd0);
        step(1'b1, 2'd1, 32'h1111_0003, 4'b0010);
        step(1'b1, 2'd1, 32'h1111_0003, 4'b0010);
        step(1'b0, 2'd1, 32'h0, 4'b0010);
        step(1'b0, 2'd1, 32'h0, 4'b0010);
        step(1'b0, 2'd1, 32'h0, 4'b0000);

        // 4: round-robin lanes with all outputs ready
        for (int i = 0; i < 8; i++)
            step(1'b1, 2'(i), 32'hC0DE_0000 + 32'(i), 4'b1111);
        step(1'b0, 2'd0, 32'h0, 4'b1111);

        // 5: lane 3 full and stalled; other lanes unaffected
        step(1'b1, 2'd3, 32'h3333_0001, 4'b0000);
        step(1'b1, 2'd3, 32'h3333_0002, 4'b0000);
        step(1'b0, 2'd3, 32'h0, 4'b0000);
        step(1'b1, 2'd0, 32'h0000_00AA, 4'b0000);
        step(1'b1, 2'd3, 32'h3333_0003, 4'b0001);
        step(1'b0, 2'd0, 32'h0, 4'b0000);

        // 6: asynchronous reset with words buffered in several lanes
        step(1'b1, 2'd0, 32'h6666_0001, 4'b0000);
        step(1'b1, 2'd2, 32'h6666_0002, 4'b0000);
        #2;
        reset = 1'b1;
        #1;
        chk("async reset out_valid", {28'd0, out_valid}, 32'd0);
        chk("async reset in_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("async reset out_data[%0d]", k), out_data[k*WIDTH +: WIDTH], 32'd0);
            sb[k].delete();
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 2'd3, 32'h7777_0001, 4'b0000);
        step(1'b0, 2'd0, 32'h0, 4'b1000);
        step(1'b0, 2'd0, 32'h0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
